// File: rtl/color_led_driver_if.sv
// Bundle of the enable/colour inputs and LED/status outputs of color_led_driver.
// change_cnt exists only when COLOR_LED_DRIVER_STATUS_EN is defined.
interface color_led_driver_if;
    logic       en;
    logic [1:0] color;
    logic       led_blue;
    logic       led_red;
    logic       busy;
    logic       err;
`ifdef COLOR_LED_DRIVER_STATUS_EN
    logic [7:0] change_cnt;
`endif

    modport master (
        output en, color,
`ifdef COLOR_LED_DRIVER_STATUS_EN
        input  change_cnt,
`endif
        input  led_blue, led_red, busy, err
    );

    modport slave (
        input  en, color,
`ifdef COLOR_LED_DRIVER_STATUS_EN
        output change_cnt,
`endif
        output led_blue, led_red, busy, err
    );
endinterface

// File: rtl/color_led_driver.sv
// Latches a Blue/Red colour code and drives the matching LED with fixed-duty PWM, with a
// both-off dead-time on every change. COLOR_LED_DRIVER_STATUS_EN adds a saturating change counter.
module color_led_driver #(
    parameter int PWM_PERIOD   = 16,
    parameter int DUTY         = 12,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    color_led_driver_if.slave bus
);
    localparam int PW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PWM_LAST   = PW'(PWM_PERIOD - 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES - 1);
    localparam logic [31:0]   DUTY_W     = 32'(DUTY);

    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("color_led_driver: BLANK_CYCLES must be at least 1");
    end
    if (PWM_PERIOD < 2) begin : g_bad_period
        $error("color_led_driver: PWM_PERIOD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [1:0]    cur_color_r, cur_color_s;
    logic [BW-1:0] blank_cnt_r, blank_cnt_s;
    logic [PW-1:0] pwm_cnt_r, pwm_cnt_s;
    logic          led_blue_r, led_blue_s;
    logic          led_red_r, led_red_s;
    logic          busy_r, busy_s;
    logic          err_r, err_s;
    logic          pwm_on_s;
    logic          valid_s;
    logic          is_new_s;
`ifdef COLOR_LED_DRIVER_STATUS_EN
    logic [7:0]    change_cnt_r, change_cnt_s;
`endif

    assign valid_s  = (bus.color == 2'h1) || (bus.color == 2'h2);
    assign is_new_s = valid_s && ((state_r == IDLE) || (bus.color != cur_color_r));

    // Next-state decode; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_s     = state_r;
        cur_color_s = cur_color_r;
        blank_cnt_s = blank_cnt_r;
        pwm_cnt_s   = pwm_cnt_r;
        err_s       = 1'b0;
`ifdef COLOR_LED_DRIVER_STATUS_EN
        change_cnt_s = change_cnt_r;
`endif
        if (!bus.en) begin
            state_s     = IDLE;
            cur_color_s = 2'h0;
            blank_cnt_s = '0;
            pwm_cnt_s   = '0;
`ifdef COLOR_LED_DRIVER_STATUS_EN
            change_cnt_s = 8'h00;
`endif
        end else begin
            err_s = ~valid_s;
            if (is_new_s) begin
                // Any accepted change (including one during BLANK) restarts the dead time.
                state_s     = BLANK;
                cur_color_s = bus.color;
                blank_cnt_s = BLANK_LOAD;
                pwm_cnt_s   = '0;
`ifdef COLOR_LED_DRIVER_STATUS_EN
                if (change_cnt_r != 8'hFF) begin
                    change_cnt_s = change_cnt_r + 8'h01;
                end else begin
                    change_cnt_s = change_cnt_r;
                end
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        state_s = IDLE;
                    end
                    BLANK: begin
                        if (blank_cnt_r == '0) begin
                            state_s   = DRIVE;
                            pwm_cnt_s = '0;
                        end else begin
                            blank_cnt_s = blank_cnt_r - BW'(1);
                        end
                    end
                    DRIVE: begin
                        if (pwm_cnt_r == PWM_LAST) begin
                            pwm_cnt_s = '0;
                        end else begin
                            pwm_cnt_s = pwm_cnt_r + PW'(1);
                        end
                    end
                    default: begin
                        state_s     = IDLE;
                        cur_color_s = 2'h0;
                        blank_cnt_s = '0;
                        pwm_cnt_s   = '0;
                    end
                endcase
            end
        end

        pwm_on_s   = (32'(pwm_cnt_s) < DUTY_W);
        led_blue_s = (state_s == DRIVE) && (cur_color_s == 2'h1) && pwm_on_s;
        led_red_s  = (state_s == DRIVE) && (cur_color_s == 2'h2) && pwm_on_s;
        busy_s     = (state_s == BLANK);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cur_color_r <= 2'h0;
            blank_cnt_r <= '0;
            pwm_cnt_r   <= '0;
            led_blue_r  <= 1'b0;
            led_red_r   <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef COLOR_LED_DRIVER_STATUS_EN
            change_cnt_r <= 8'h00;
`endif
        end else begin
            state_r     <= state_s;
            cur_color_r <= cur_color_s;
            blank_cnt_r <= blank_cnt_s;
            pwm_cnt_r   <= pwm_cnt_s;
            led_blue_r  <= led_blue_s;
            led_red_r   <= led_red_s;
            busy_r      <= busy_s;
            err_r       <= err_s;
`ifdef COLOR_LED_DRIVER_STATUS_EN
            change_cnt_r <= change_cnt_s;
`endif
        end
    end

    assign bus.led_blue = led_blue_r;
    assign bus.led_red  = led_red_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
`ifdef COLOR_LED_DRIVER_STATUS_EN
    assign bus.change_cnt = change_cnt_r;
`endif
endmodule

// File: doc/color_led_driver.md
# color_led_driver

Downstream consumer of the two-bit colour code produced by the colour state machine (2'h1 = Blue, 2'h2 = Red). It latches the current colour and drives the matching LED with a fixed-duty PWM. Every colour change inserts a dead-time window with both LEDs off. Invalid codes are flagged and ignored.

## Interface
Parameters:
- PWM_PERIOD, 16, PWM period in cycles; must be at least 2.
- DUTY, 12, on-cycles per period. 0 means always off; DUTY >= PWM_PERIOD means always on.
- BLANK_CYCLES, 4, dead-time length in cycles; must be at least 1. A value of 0 is an elaboration-time error.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- en  input  1  enable. When low, the block returns to IDLE and both LEDs turn off.
- color  input  2  colour code from the upstream FSM.
- led_blue  output  1  Blue LED drive (registered).
- led_red  output  1  Red LED drive (registered).
- busy  output  1  high while in BLANK (registered).
- err  output  1  one-cycle pulse: an invalid code was sampled (registered).

## Operation
- State register: IDLE, BLANK, DRIVE.
- Other registers:
  - cur_color, 2 bits.
  - blank_cnt, $clog2(BLANK_CYCLES+1) bits.
  - pwm_cnt, $clog2(PWM_PERIOD) bits.
- Reset values: state=IDLE, cur_color=0, all counters 0, led_blue=led_red=busy=err=0.
- Valid codes are 2'h1 and 2'h2. Codes 2'h0 and 2'h3 are invalid.
  - With en=1, an invalid code sets err=1 for the next cycle and has no other effect; state and counters continue unchanged.
  - err is 0 whenever en=0.
- A valid code is "new" when it differs from cur_color or the state is IDLE.
- IDLE:
  - LEDs off, busy=0.
  - A new valid code latches cur_color, loads blank_cnt=BLANK_CYCLES-1 and moves to BLANK.
- BLANK:
  - LEDs off, busy=1.
  - If a new valid code arrives: latch it, reload blank_cnt=BLANK_CYCLES-1, stay in BLANK (dead time restarts).
  - Otherwise, if blank_cnt==0: move to DRIVE with pwm_cnt=0.
  - Otherwise: decrement blank_cnt.
- DRIVE:
  - busy=0.
  - pwm_cnt increments and wraps from PWM_PERIOD-1 to 0.
  - The LED selected by cur_color equals (pwm_cnt < DUTY); the other LED is 0.
  - A new valid code latches it, loads blank_cnt and moves to BLANK.
  - A repeat of the same code has no effect; the PWM phase is not disturbed.
- en=0 (any state): next state IDLE, cur_color=0, counters cleared, outputs 0. While en=0, color is not sampled.
- Both LEDs are never high in the same cycle.

## Timing
- All outputs are registers loaded from the next-state decode. A code sampled at edge k is reflected on the outputs right after edge k.
- Change sampled at edge k:
  - LEDs are 0 and busy=1 for cycles k .. k+BLANK_CYCLES-1.
  - At edge k+BLANK_CYCLES the state enters DRIVE with pwm_cnt=0, and the new LED rises (if DUTY>0) with busy=0.
- PWM: the LED is high for DUTY consecutive cycles starting at phase 0, then low for PWM_PERIOD-DUTY cycles, repeating.
- Reset asserted mid-operation clears every register immediately (asynchronous), regardless of state.
- Simultaneous en=0 and a valid code: en=0 wins.

## Configuration
- Macro COLOR_LED_DRIVER_STATUS_EN.
- Defined:
  - Adds output port change_cnt (8 bits, reset 0).
  - It increments on every accepted new valid code (each entry to BLANK, including restarts) and saturates at 8'hFF.
  - It is cleared by rst or en=0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset, then en=1, color=2'h1 held (defaults):
  - busy=1 and LEDs 0 for 4 cycles.
  - Then led_blue shows a 12-high / 4-low pattern repeating every 16 cycles; led_red stays 0.
- In DRIVE Blue, color switches to 2'h2 for one cycle, then back to 2'h1 two cycles later:
  - The blank window restarts on the second change.
  - led_blue resumes 4 cycles after the last change; led_red never rises.
- color=2'h3 for one cycle while in DRIVE:
  - err pulses for exactly 1 cycle.
  - LED pattern and pwm_cnt phase are unchanged.
- en deasserted mid-PWM:
  - The next cycle has LEDs 0, busy 0, and state IDLE.
  - Re-enabling with the same colour starts a fresh 4-cycle blank.
- rst asserted during BLANK, between clock edges:
  - Outputs drop to 0 immediately.
  - After release, no LED rises until a new valid code plus 4 blank cycles.
- With COLOR_LED_DRIVER_STATUS_EN defined, apply 300 alternating valid changes: change_cnt ends at 8'hFF. Separately set DUTY=0 (LED always 0) and DUTY=16 (LED always 1 in DRIVE).
